// File: rtl/vdc_pixelshift.sv
// vdc_pixelshift: C128 VDC pixel generator.
//
// Takes the character bitmap and attribute latches filled by the RAM interface and shifts
// them out as a 4-bit RGBI pixel stream, one pixel per enable. Applies the text-mode
// attribute rules (underline, blink, reverse), global reverse, and the bitmap-mode colour
// rules.
//
// Optional feature: define VDC_CURSOR_EN to build the hardware cursor. Without it the cursor
// term is constant 0 and the cursor ports are accepted but ignored.
//
// Ports:
//   clk_i, reset_ni          clock, synchronous active-low reset
//   enable_i                 pixel clock enable; all state advances only when high
//   new_col_i                first pixel of a character column
//   fetch_line_i, frame_i    start of scanline / start of frame
//   disp_en_i                current column lies inside the display window
//   col_i, line_i            current character column / scanline within the row
//   rowbuf_i                 attribute buffer holding the current row
//   attrbuf_i, charbuf_i     attribute and character bitmap latches
//   reg_*_i                  VDC register values
//   dispaddr_i               row start address (cursor compare)
//   rgbi_o, de_o             pixel colour and display enable, one enable after the state

module vdc_pixelshift #(
    parameter int unsigned S_LATCH_WIDTH = 80,
    parameter int unsigned C_LATCH_WIDTH = 8,
    parameter int unsigned C_LATCH_BITS  = $clog2(C_LATCH_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    enable_i,
    input  logic                    new_col_i,
    input  logic                    fetch_line_i,
    input  logic                    frame_i,
    input  logic                    disp_en_i,
    input  logic [7:0]              col_i,
    input  logic [4:0]              line_i,
    input  logic                    rowbuf_i,
    input  logic [7:0]              attrbuf_i [2][S_LATCH_WIDTH],
    input  logic [7:0]              charbuf_i [C_LATCH_WIDTH],
    input  logic [3:0]              reg_cth_i,
    input  logic [3:0]              reg_cdh_i,
    input  logic                    reg_text_i,
    input  logic                    reg_atr_i,
    input  logic                    reg_rvs_i,
    input  logic                    reg_semi_i,
    input  logic [4:0]              reg_ul_i,
    input  logic [3:0]              reg_fg_i,
    input  logic [3:0]              reg_bg_i,
    input  logic                    reg_cbrate_i,
    input  logic [15:0]             dispaddr_i,
    input  logic [15:0]             reg_cp_i,
    input  logic [4:0]              reg_cs_i,
    input  logic [4:0]              reg_ce_i,
    input  logic [1:0]              reg_cm_i,
    output logic [3:0]              rgbi_o,
    output logic                    de_o
);

    localparam int unsigned ColBits = $clog2(S_LATCH_WIDTH);

    logic [7:0]              char_q, char_d;
    logic [7:0]              attr_q, attr_d;
    logic [C_LATCH_BITS-1:0] ci_q, ci_d;
    logic [3:0]              p_q, p_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [3:0]              rgbi_q, rgbi_d;
    logic                    de_q, de_d;

    logic                    raw_bit;
    logic                    blink_phase;
    logic                    cursor_on;
    logic                    pix_bit;
    logic [3:0]              fg;
    logic [3:0]              bg;
    logic [3:0]              pix_colour;
    logic [C_LATCH_BITS-1:0] load_idx;
    logic [C_LATCH_BITS-1:0] load_idx_next;
    logic [7:0]              attr_fetch;

    // Raw bitmap bit for the current pixel position within the character cell.
    always_comb begin
        raw_bit = 1'b0;
        if (p_q > reg_cth_i) begin
            raw_bit = 1'b0;
        end else if ((p_q <= reg_cdh_i) && (p_q <= 4'd7)) begin
            // ~p[2:0] == 7 - p for p in 0..7: MSB is shifted out first.
            raw_bit = char_q[~p_q[2:0]];
        end else begin
            // Inter-character gap: semigraphics stretches bit0 across it.
            raw_bit = reg_semi_i & char_q[0];
        end
    end

    assign blink_phase = reg_cbrate_i ? cnt_q[4] : cnt_q[3];

`ifdef VDC_CURSOR_EN
    logic [15:0] cur_addr;
    logic        cur_visible;

    assign cur_addr = dispaddr_i + {8'd0, col_i};

    always_comb begin
        cur_visible = 1'b0;
        unique case (reg_cm_i)
            2'b00:   cur_visible = 1'b1;
            2'b01:   cur_visible = 1'b0;
            2'b10:   cur_visible = ~cnt_q[3];
            2'b11:   cur_visible = ~cnt_q[4];
            default: cur_visible = 1'b0;
        endcase
    end

    assign cursor_on = ~reg_text_i && (cur_addr == reg_cp_i) &&
                       (line_i >= reg_cs_i) && (line_i <= reg_ce_i) && cur_visible;
`else
    logic unused_cursor;
    assign unused_cursor = ^{dispaddr_i, reg_cp_i, reg_cs_i, reg_ce_i, reg_cm_i};
    assign cursor_on     = 1'b0;
`endif

    // Attribute modifiers and colour selection.
    always_comb begin
        pix_bit = raw_bit;
        if (!reg_text_i) begin
            if (attr_q[5] && (line_i == reg_ul_i)) begin
                pix_bit = 1'b1;
            end
            if (attr_q[4] && blink_phase) begin
                pix_bit = 1'b0;
            end
            pix_bit = pix_bit ^ attr_q[6] ^ reg_rvs_i ^ cursor_on;
        end else begin
            pix_bit = pix_bit ^ reg_rvs_i;
        end

        if (reg_atr_i) begin
            fg = attr_q[3:0];
            bg = reg_text_i ? attr_q[7:4] : reg_bg_i;
        end else begin
            fg = reg_fg_i;
            bg = reg_bg_i;
        end

        pix_colour = disp_en_i ? (pix_bit ? fg : bg) : reg_bg_i;
    end

    // A fetchLine coinciding with newCol restarts the ring at index 0 for this load.
    assign load_idx      = fetch_line_i ? '0 : ci_q;
    assign load_idx_next = (load_idx == C_LATCH_BITS'(C_LATCH_WIDTH - 1)) ? '0
                         : load_idx + C_LATCH_BITS'(1);

    always_comb begin
        attr_fetch = 8'd0;
        if (reg_atr_i && (32'(col_i) < S_LATCH_WIDTH)) begin
            attr_fetch = attrbuf_i[rowbuf_i][col_i[ColBits-1:0]];
        end
    end

    always_comb begin
        char_d = char_q;
        attr_d = attr_q;
        ci_d   = ci_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        rgbi_d = rgbi_q;
        de_d   = de_q;
        if (enable_i) begin
            rgbi_d = pix_colour;
            de_d   = disp_en_i;
            if (frame_i) begin
                cnt_d = cnt_q + 5'd1;
            end
            if (fetch_line_i) begin
                ci_d = '0;
            end
            if (new_col_i) begin
                if (disp_en_i) begin
                    char_d = charbuf_i[load_idx];
                    ci_d   = load_idx_next;
                    attr_d = attr_fetch;
                    p_d    = 4'd0;
                end else begin
                    char_d = 8'd0;
                    attr_d = 8'd0;
                end
            end else if (p_q != 4'hF) begin
                p_d = p_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            char_q <= 8'd0;
            attr_q <= 8'd0;
            ci_q   <= '0;
            p_q    <= 4'd0;
            cnt_q  <= 5'd0;
            rgbi_q <= 4'd0;
            de_q   <= 1'b0;
        end else begin
            char_q <= char_d;
            attr_q <= attr_d;
            ci_q   <= ci_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            rgbi_q <= rgbi_d;
            de_q   <= de_d;
        end
    end

    assign rgbi_o = rgbi_q;
    assign de_o   = de_q;

endmodule

// File: tb/tb_vdc_pixelshift.sv
module tb_vdc_pixelshift;

    localparam int SW = 80;
    localparam int CW = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, new_col, fetch_line, frame, disp_en, rowbuf;
    logic [7:0]  col;
    logic [4:0]  line;
    logic [7:0]  attrbuf [2][SW];
    logic [7:0]  charbuf [CW];
    logic [3:0]  reg_cth, reg_cdh, reg_fg, reg_bg;
    logic        reg_text, reg_atr, reg_rvs, reg_semi, reg_cbrate;
    logic [4:0]  reg_ul, reg_cs, reg_ce;
    logic [15:0] dispaddr, reg_cp;
    logic [1:0]  reg_cm;
    logic [3:0]  rgbi;
    logic        de;

    vdc_pixelshift #(.S_LATCH_WIDTH(SW), .C_LATCH_WIDTH(CW)) dut (
        .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .new_col_i(new_col),
        .fetch_line_i(fetch_line), .frame_i(frame), .disp_en_i(disp_en), .col_i(col),
        .line_i(line), .rowbuf_i(rowbuf), .attrbuf_i(attrbuf), .charbuf_i(charbuf),
        .reg_cth_i(reg_cth), .reg_cdh_i(reg_cdh), .reg_text_i(reg_text), .reg_atr_i(reg_atr),
        .reg_rvs_i(reg_rvs), .reg_semi_i(reg_semi), .reg_ul_i(reg_ul), .reg_fg_i(reg_fg),
        .reg_bg_i(reg_bg), .reg_cbrate_i(reg_cbrate), .dispaddr_i(dispaddr), .reg_cp_i(reg_cp),
        .reg_cs_i(reg_cs), .reg_ce_i(reg_ce), .reg_cm_i(reg_cm), .rgbi_o(rgbi), .de_o(de)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: the character cell being shown and where we are in it.
    int   m_char, m_attr, m_ci, m_p, m_cnt;
    logic [3:0] exp_rgbi;
    logic       exp_de;
    bit         exp_valid = 1'b0;

    function automatic int cursor_on();
`ifdef VDC_CURSOR_EN
        int vis;
        if (reg_text) return 0;
        if (((int'(dispaddr) + int'(col)) % 65536) != int'(reg_cp)) return 0;
        if (line < reg_cs || line > reg_ce) return 0;
        case (reg_cm)
            2'd0: vis = 1;
            2'd1: vis = 0;
            2'd2: vis = ((m_cnt / 8) % 2 == 0) ? 1 : 0;
            default: vis = ((m_cnt / 16) % 2 == 0) ? 1 : 0;
        endcase
        return vis;
`else
        return 0;
`endif
    endfunction

    function automatic logic [3:0] model_pixel();
        int b, phase;
        logic [3:0] fg, bg;
        if (!disp_en) return reg_bg;
        if (m_p > int'(reg_cth)) b = 0;
        else if (m_p <= int'(reg_cdh) && m_p <= 7) b = (m_char >> (7 - m_p)) & 1;
        else b = reg_semi ? (m_char & 1) : 0;
        phase = reg_cbrate ? (m_cnt / 16) % 2 : (m_cnt / 8) % 2;
        if (!reg_text) begin
            if (((m_attr >> 5) & 1) == 1 && line == reg_ul) b = 1;
            if (((m_attr >> 4) & 1) == 1 && phase == 1) b = 0;
            b = b ^ ((m_attr >> 6) & 1) ^ int'(reg_rvs) ^ cursor_on();
        end else begin
            b = b ^ int'(reg_rvs);
        end
        if (reg_atr) begin
            fg = 4'(m_attr % 16);
            bg = reg_text ? 4'(m_attr / 16) : reg_bg;
        end else begin
            fg = reg_fg;
            bg = reg_bg;
        end
        return (b != 0) ? fg : bg;
    endfunction

    // Apply current inputs to the model, then advance one clock.
    task automatic step();
        int idx;
        if (!reset_n) begin
            m_char = 0; m_attr = 0; m_ci = 0; m_p = 0; m_cnt = 0;
            exp_rgbi = 4'h0; exp_de = 1'b0;
        end else if (enable) begin
            exp_rgbi = model_pixel();
            exp_de   = disp_en;
            if (frame) m_cnt = (m_cnt + 1) % 32;
            if (fetch_line) m_ci = 0;
            if (new_col) begin
                if (disp_en) begin
                    idx    = m_ci;
                    m_char = int'(charbuf[idx]);
                    m_ci   = (idx + 1) % CW;
                    m_attr = (reg_atr && int'(col) < SW) ? int'(attrbuf[rowbuf][col]) : 0;
                    m_p    = 0;
                end else begin
                    m_char = 0;
                    m_attr = 0;
                end
            end else if (m_p < 15) begin
                m_p = m_p + 1;
            end
        end
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (exp_valid) begin
            #1;
            checks++;
            if (rgbi !== exp_rgbi || de !== exp_de) begin
                errors++;
                $display("FAIL model t=%0t rgbi=%h de=%b required rgbi=%h de=%b",
                         $time, rgbi, de, exp_rgbi, exp_de);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic load_col();
        new_col = 1'b1; enable = 1'b1; disp_en = 1'b1;
        step();
        new_col = 1'b0; fetch_line = 1'b0;
    endtask

    task automatic collect(input int n, output logic [3:0] px [16]);
        for (int i = 0; i < 16; i++) px[i] = 4'hx;
        for (int i = 0; i < n; i++) begin
            step();
            px[i] = rgbi;
        end
    endtask

    logic [3:0] px [16];
    logic [3:0] want8 [8];

    initial begin
        reset_n = 0; enable = 1; new_col = 0; fetch_line = 0; frame = 0; disp_en = 0;
        rowbuf = 0; col = 0; line = 0;
        reg_cth = 7; reg_cdh = 7; reg_text = 0; reg_atr = 0; reg_rvs = 0; reg_semi = 0;
        reg_ul = 31; reg_fg = 4'hF; reg_bg = 4'h0; reg_cbrate = 0;
        dispaddr = 0; reg_cp = 16'hFFFF; reg_cs = 0; reg_ce = 0; reg_cm = 2'b01;
        for (int r = 0; r < 2; r++) for (int c = 0; c < SW; c++) attrbuf[r][c] = 8'h00;
        for (int i = 0; i < CW; i++) charbuf[i] = 8'h00;
        @(negedge clk);
        step();
        step();
        chk("reset_rgbi", rgbi, 4'h0);
        chk("reset_de", {3'b0, de}, 4'h0);
        reset_n = 1;

        // Plain text shift-out of A5.
        charbuf[0] = 8'hA5;
        load_col();
        collect(8, px);
        want8 = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF};
        for (int i = 0; i < 8; i++) chk($sformatf("text_a5_px%0d", i), px[i], want8[i]);

        // Semigraphics gap extension.
        do_reset();
        reg_cth = 9; reg_semi = 1; charbuf[0] = 8'h01;
        load_col();
        collect(10, px);
        chk("semi_px7", px[7], 4'hF);
        chk("semi_px8", px[8], 4'hF);
        chk("semi_px9", px[9], 4'hF);
        do_reset();
        reg_semi = 0;
        load_col();
        collect(10, px);
        chk("nosemi_px8", px[8], 4'h0);
        chk("nosemi_px9", px[9], 4'h0);
        reg_cth = 7;

        // Underline + blink attribute.
        do_reset();
        reg_atr = 1; reg_bg = 4'h1; col = 5; line = 4; reg_ul = 4;
        attrbuf[0][5] = 8'h3C; charbuf[0] = 8'h00;
        load_col();
        collect(8, px);
        for (int i = 0; i < 8; i++) chk($sformatf("ul_px%0d", i), px[i], 4'hC);
        frame = 1;
        for (int i = 0; i < 8; i++) step();
        frame = 0;
        fetch_line = 1;
        load_col();
        collect(8, px);
        for (int i = 0; i < 8; i++) chk($sformatf("blink_px%0d", i), px[i], 4'h1);

        // Bitmap mode colours.
        do_reset();
        reg_text = 1; reg_atr = 1; col = 6; attrbuf[0][6] = 8'h52; charbuf[0] = 8'hF0;
        load_col();
        collect(8, px);
        want8 = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h5, 4'h5, 4'h5, 4'h5};
        for (int i = 0; i < 8; i++) chk($sformatf("bitmap_px%0d", i), px[i], want8[i]);

        // fetchLine with newCol restarts the ring at 0.
        do_reset();
        reg_text = 0; reg_atr = 0; reg_bg = 4'h0; reg_ul = 31;
        for (int i = 0; i < CW; i++) charbuf[i] = 8'h00;
        charbuf[0] = 8'h80; charbuf[1] = 8'h40;
        for (int i = 0; i < 5; i++) begin
            load_col();
            step();
        end
        fetch_line = 1;
        load_col();
        collect(2, px);
        chk("fl_idx0_px0", px[0], 4'hF);
        chk("fl_idx0_px1", px[1], 4'h0);
        load_col();
        collect(2, px);
        chk("fl_idx1_px0", px[0], 4'h0);
        chk("fl_idx1_px1", px[1], 4'hF);

        // Cursor.
        do_reset();
        charbuf[0] = 8'h00; dispaddr = 16'h0100; col = 4; reg_cp = 16'h0104;
        reg_cs = 2; reg_ce = 6; line = 3; reg_cm = 2'b00;
        load_col();
        collect(8, px);
`ifdef VDC_CURSOR_EN
        for (int i = 0; i < 8; i++) chk($sformatf("cursor_px%0d", i), px[i], 4'hF);
`else
        for (int i = 0; i < 8; i++) chk($sformatf("cursor_px%0d", i), px[i], 4'h0);
`endif

        // Randomized run against the model.
        for (int r = 0; r < 2; r++) for (int c = 0; c < SW; c++) attrbuf[r][c] = 8'($urandom);
        for (int i = 0; i < CW; i++) charbuf[i] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            enable     = ($urandom_range(0, 3) != 0);
            new_col    = ($urandom_range(0, 5) == 0);
            fetch_line = ($urandom_range(0, 39) == 0);
            frame      = ($urandom_range(0, 9) == 0);
            disp_en    = ($urandom_range(0, 4) != 0);
            col        = 8'($urandom_range(0, 90));
            line       = 5'($urandom);
            rowbuf     = 1'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                reg_cth = 4'($urandom); reg_cdh = 4'($urandom);
                reg_text = 1'($urandom); reg_atr = 1'($urandom); reg_rvs = 1'($urandom);
                reg_semi = 1'($urandom); reg_ul = 5'($urandom); reg_fg = 4'($urandom);
                reg_bg = 4'($urandom); reg_cbrate = 1'($urandom);
                dispaddr = 16'($urandom);
                reg_cp = dispaddr + 16'($urandom_range(0, 90));
                reg_cs = 5'($urandom); reg_ce = 5'($urandom); reg_cm = 2'($urandom);
            end
            if ($urandom_range(0, 99) == 0) charbuf[$urandom_range(0, CW - 1)] = 8'($urandom);
            step();
        end
        exp_valid = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdc_pixelshift.md
Name: vdc_pixelshift

Overview:
- Pixel generator for the C128 VDC.
- Consumes the row/column latches that the VDC RAM interface fills (screen, attribute and character buffers) and serializes them into a 4-bit RGBI pixel stream, one pixel per pixel-clock enable.
- Applies the text-mode and bitmap-mode attribute rules and the blink, underline and reverse modifiers.
- Sits between the RAM interface and the video timing/output stage.

Parameters:
- S_LATCH_WIDTH, 80: entries per screen/attribute row buffer.
- C_LATCH_WIDTH, 8: entries in the character-data latch ring.
- C_LATCH_BITS, $clog2(C_LATCH_WIDTH): character read-index width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- enable  in  1  pixel clock enable; all state advances only when high
- newCol  in  1  first pixel of a character column (qualified by enable)
- fetchLine  in  1  start of scanline (qualified by enable)
- frame  in  1  start of frame (qualified by enable)
- dispEn  in  1  current column lies inside the display window
- col  in  8  current character column
- line  in  5  current scanline within the character row
- rowbuf  in  1  buffer select holding the current row
- attrbuf  in  8 x S_LATCH_WIDTH x 2  attribute latches
- charbuf  in  8 x C_LATCH_WIDTH  character bitmap latches
- reg_cth  in  4  character total horizontal minus 1
- reg_cdh  in  4  character displayed horizontal minus 1
- reg_text  in  1  1 = bitmap mode, 0 = text mode
- reg_atr  in  1  attribute enable
- reg_rvs  in  1  global reverse screen
- reg_semi  in  1  semigraphics: extend bit0 into the inter-character gap
- reg_ul  in  5  underline scanline
- reg_fg  in  4  foreground colour when attributes are off
- reg_bg  in  4  background/border colour
- reg_cbrate  in  1  character blink rate: 0 = 1/16 frames, 1 = 1/32 frames
- dispaddr  in  16  row start address (cursor compare)
- reg_cp  in  16  cursor position
- reg_cs  in  5  cursor start scanline
- reg_ce  in  5  cursor end scanline
- reg_cm  in  2  cursor mode
- rgbi  out  4  pixel colour
- de  out  1  registered display enable aligned with rgbi

Behaviour:
- Reset: rgbi=0, de=0, shift register=0, attribute latch=0, ci=0, pixel counter p=0, blink counter=0.
- All state and outputs update only on edges where enable=1. Output latency: 1 enable. The pixel computed from state at edge N appears on rgbi/de after edge N.
- fetchLine: ci<=0. If newCol is also asserted on the same cycle, the load uses index 0 and ci then becomes 1.
- newCol with dispEn:
  - char<=charbuf[ci]; ci<=(ci+1) mod C_LATCH_WIDTH.
  - attr<=attrbuf[rowbuf][col] if reg_atr and col<S_LATCH_WIDTH, else 0.
  - p<=0.
- newCol without dispEn: char<=0, attr<=0, ci unchanged.
- Otherwise p<=p+1, saturating at 15.
- Raw bit, evaluated in order:
  - p>reg_cth: 0
  - else p<=reg_cdh and p<=7: char[7-p]
  - else reg_semi ? char[0] : 0
- Text-mode modifiers, reg_text=0, applied in order:
  - underline: attr[5] and line==reg_ul forces 1
  - blink: attr[4] and blink phase=1 forces 0
  - XOR attr[6]
  - XOR reg_rvs
  - XOR cursor
- Blink counter: 5-bit, increments on frame, wraps 31->0. Phase = reg_cbrate ? cnt[4] : cnt[3].
- Colour selection:
  - Text mode, reg_atr=1: fg=attr[3:0], bg=reg_bg.
  - Bitmap mode, reg_atr=1: fg=attr[3:0], bg=attr[7:4]; underline/blink/attr reverse ignored; reg_rvs still applies.
  - reg_atr=0: fg=reg_fg, bg=reg_bg.
- Output: rgbi = bit ? fg : bg. de<=dispEn registered. When dispEn=0: rgbi=reg_bg.
- reset_n low mid-line clears all state. The first newCol after release reads charbuf[0].

Optional Feature:
- Macro: VDC_CURSOR_EN.
- Defined:
  - Cursor active when text mode, dispaddr+col==reg_cp (16-bit wrap), and reg_cs<=line<=reg_ce.
  - reg_cm: 00 solid, 01 off, 10 blink at cnt[3], 11 blink at cnt[4]; visible when the selected bit=0.
  - Active cursor XORs the pixel bit.
- Undefined: cursor term is constant 0. Cursor ports remain present and are ignored.

Test Plan:
- Text, reg_atr=0, reg_cth=7, reg_cdh=7, charbuf[0]=8'hA5, reg_fg=4'hF, reg_bg=4'h0, newCol+dispEn -> rgbi sequence F,0,F,0,0,F,0,F, first pixel 1 enable after the load.
- reg_cth=9, reg_semi=1, charbuf[0]=8'h01 -> pixels 8 and 9 = fg. With reg_semi=0 -> pixels 8 and 9 = bg.
- attr=8'h3C (underline, blink, fg C), line==reg_ul, blink counter=0 -> all 8 pixels = C. After 8 frame pulses (cnt[3]=1) -> all pixels = reg_bg.
- Bitmap, reg_atr=1, attr=8'h52, char=8'hF0 -> 2,2,2,2,5,5,5,5.
- fetchLine and newCol asserted together with ci=5 -> charbuf[0] used, ci=1.
- VDC_CURSOR_EN, reg_cm=00, dispaddr=0x0100, col=4, reg_cp=0x0104, line within reg_cs..reg_ce, char=0 -> 8 fg pixels. Macro undefined -> 8 bg pixels.
